// File: rtl/instruction_fetch_buffer_pkg.sv
// Shared pipeline constants: XLEN, NOP bubble encoding, fetch buffer depth.
// Also reused by the hazard unit and the ID/EX register for bubble insertion.
package instruction_fetch_buffer_pkg;

    localparam int XLEN = 32;

    // ADDI x0,x0,0
    localparam logic [XLEN-1:0] NOP_ENCODING = 32'h0000_0013;

    localparam int FETCH_BUF_DEPTH = 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_word_t;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instruction_fetch_buffer_sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO: storage array, pointers, occupancy.
// Flush empties it at the next edge; storage contents are never cleared.
module instruction_fetch_buffer_sync_fifo_fwft #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^PTR_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/instruction_fetch_buffer.sv
// Fetch-to-decode buffer: FWFT FIFO of {pc, inst} pairs with flush priority,
// NOP substitution when empty and the PC+4 adder for decode.
module instruction_fetch_buffer
    import instruction_fetch_buffer_pkg::*;
#(
    parameter int              DEPTH    = FETCH_BUF_DEPTH,
    parameter int              PTR_W    = $clog2(DEPTH),
    parameter logic [XLEN-1:0] NOP_INST = NOP_ENCODING
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            IF_VALID,
    input  logic [XLEN-1:0] IF_INST,
    input  logic [XLEN-1:0] IF_PC,
    output logic            IF_READY,
    input  logic            ID_STALL,
    input  logic            FLUSH,
    output logic            ID_VALID,
    output logic [XLEN-1:0] ID_INST,
    output logic [XLEN-1:0] ID_PC,
    output logic [XLEN-1:0] ID_PC_PLUS4,
    output logic [PTR_W:0]  COUNT
);

    fetch_word_t wr_word;
    fetch_word_t head;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;

    // Flush wins: the word on IF_* and the head are both discarded
    assign push = IF_VALID & IF_READY & ~FLUSH;
    assign pop  = ID_VALID & ~ID_STALL & ~FLUSH;

    assign wr_word.pc   = IF_PC;
    assign wr_word.inst = IF_INST;

    instruction_fetch_buffer_sync_fifo_fwft #(
        .WIDTH ($bits(fetch_word_t)),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .pop   (pop),
        .flush (FLUSH),
        .wdata (wr_word),
        .rdata (head),
        .count (COUNT),
        .full  (full),
        .empty (empty)
    );

    // Ready depends on registered occupancy only
    assign IF_READY    = ~full;
    assign ID_VALID    = ~empty;
    assign ID_INST     = ID_VALID ? head.inst : NOP_INST;
    assign ID_PC       = ID_VALID ? head.pc : '0;
    assign ID_PC_PLUS4 = ID_VALID ? pc_plus4(head.pc) : '0;

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Directed bench for instruction_fetch_buffer (DEPTH=2).
// Expected values are hand-computed per step.
module tb_instruction_fetch_buffer;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] IA  = 32'h0050_0093;
    localparam logic [31:0] IB  = 32'h00A0_0113;
    localparam logic [31:0] IC  = 32'h0020_81B3;

    logic        CLK;
    logic        RESET;
    logic        IF_VALID;
    logic [31:0] IF_INST;
    logic [31:0] IF_PC;
    logic        IF_READY;
    logic        ID_STALL;
    logic        FLUSH;
    logic        ID_VALID;
    logic [31:0] ID_INST;
    logic [31:0] ID_PC;
    logic [31:0] ID_PC_PLUS4;
    logic [1:0]  COUNT;

    int n_asserts;
    int n_fails;

    instruction_fetch_buffer dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IF_VALID    (IF_VALID),
        .IF_INST     (IF_INST),
        .IF_PC       (IF_PC),
        .IF_READY    (IF_READY),
        .ID_STALL    (ID_STALL),
        .FLUSH       (FLUSH),
        .ID_VALID    (ID_VALID),
        .ID_INST     (ID_INST),
        .ID_PC       (ID_PC),
        .ID_PC_PLUS4 (ID_PC_PLUS4),
        .COUNT       (COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst,
                         input logic [31:0] pc, input logic stall,
                         input logic flush);
        IF_VALID = v;
        IF_INST  = inst;
        IF_PC    = pc;
        ID_STALL = stall;
        FLUSH    = flush;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic v,
                            input logic [31:0] inst, input logic [31:0] pc,
                            input logic [31:0] pc4, input logic [1:0] cnt);
        chk({tag, "_valid"}, 64'(ID_VALID), 64'(v));
        chk({tag, "_inst"}, 64'(ID_INST), 64'(inst));
        chk({tag, "_pc"}, 64'(ID_PC), 64'(pc));
        chk({tag, "_pc4"}, 64'(ID_PC_PLUS4), 64'(pc4));
        chk({tag, "_count"}, 64'(COUNT), 64'(cnt));
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] inst;
        n_asserts = 0;
        n_fails   = 0;
        RESET     = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // 1. asynchronous reset, checked before any clock edge
        #1 RESET = 1'b1;
        #1;
        chk_head("rst", 1'b0, NOP, 32'h0, 32'h0, 2'd0);
        chk("rst_ready", 64'(IF_READY), 64'd1);
        #1 RESET = 1'b0;
        tick();

        // 2. streaming, one word in flight
        drive(1'b1, IA, 32'h0, 1'b0, 1'b0);
        tick();
        chk_head("s0", 1'b1, IA, 32'h0, 32'h4, 2'd1);
        drive(1'b1, IB, 32'h4, 1'b0, 1'b0);
        tick();
        chk_head("s1", 1'b1, IB, 32'h4, 32'h8, 2'd1);
        drive(1'b1, IC, 32'h8, 1'b0, 1'b0);
        tick();
        chk_head("s2", 1'b1, IC, 32'h8, 32'hC, 2'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        chk_head("s_empty", 1'b0, NOP, 32'h0, 32'h0, 2'd0);

        // empty: stall has no effect
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_head("e_stall", 1'b0, NOP, 32'h0, 32'h0, 2'd0);

        // 3. stall fill
        drive(1'b1, IA, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b1, IB, 32'h4, 1'b1, 1'b0);
        tick();
        chk("f_ready_full", 64'(IF_READY), 64'd0);
        drive(1'b1, IC, 32'h8, 1'b1, 1'b0);
        tick();
        chk_head("f_hold", 1'b1, IA, 32'h0, 32'h4, 2'd2);
        chk("f_ready_hold", 64'(IF_READY), 64'd0);

        // 4. full with pop: no push this cycle
        drive(1'b1, IC, 32'h8, 1'b0, 1'b0);
        tick();
        chk_head("f_pop", 1'b1, IB, 32'h4, 32'h8, 2'd1);
        chk("f_ready_after", 64'(IF_READY), 64'd1);
        tick();
        chk_head("f_third", 1'b1, IC, 32'h8, 32'hC, 2'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        chk_head("f_drained", 1'b0, NOP, 32'h0, 32'h0, 2'd0);

        // 5. flush with stall and a concurrent offer
        drive(1'b1, 32'h1111_1111, 32'h10, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h2222_2222, 32'h14, 1'b1, 1'b0);
        tick();
        chk("fl_pre_count", 64'(COUNT), 64'd2);
        drive(1'b1, 32'h4444_4444, 32'h40, 1'b1, 1'b1);
        tick();
        chk_head("fl", 1'b0, NOP, 32'h0, 32'h0, 2'd0);
        chk("fl_ready", 64'(IF_READY), 64'd1);
        drive(1'b1, 32'h8888_8888, 32'h80, 1'b0, 1'b0);
        tick();
        chk_head("fl_next", 1'b1, 32'h8888_8888, 32'h80, 32'h84, 2'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();

        // 6. wrap-around across 2^32 with streaming
        for (int i = 0; i < 10; i++) begin
            pc   = 32'hFFFF_FFF0 + 32'(i * 4);
            inst = 32'h1000_0000 + 32'(i);
            drive(1'b1, inst, pc, 1'b0, 1'b0);
            tick();
            chk_head($sformatf("w%0d", i), 1'b1, inst, pc, pc + 32'd4, 2'd1);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3333_3333, 32'hFFFF_FFFC, 1'b0, 1'b0);
        tick();
        chk("w_top_pc4", 64'(ID_PC_PLUS4), 64'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();

        // 7. reset mid-operation, without a clock edge
        drive(1'b1, IA, 32'h20, 1'b1, 1'b0);
        tick();
        drive(1'b1, IB, 32'h24, 1'b1, 1'b0);
        tick();
        chk("mr_pre_count", 64'(COUNT), 64'd2);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #2 RESET = 1'b1;
        #1;
        chk_head("mr", 1'b0, NOP, 32'h0, 32'h0, 2'd0);
        chk("mr_ready", 64'(IF_READY), 64'd1);
        #1 RESET = 1'b0;
        tick();
        chk_head("mr_after", 1'b0, NOP, 32'h0, 32'h0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_buffer.md
Name: instruction_fetch_buffer

Overview:
- Upstream neighbour of the decode stage. Holds fetched instruction/PC pairs between the fetch unit and decode: immediate select, register file and control unit all consume ID_INST.
- Small first-word-fall-through FIFO with a valid/ready handshake on the fetch side and a stall/flush interface on the decode side.
- Replaces the plain IF/ID register so that fetch can run ahead by DEPTH words while decode stalls.

Parameters:
- DEPTH, 2, number of instruction entries; power of two, 2..8.
- PTR_W, 1, pointer width = log2(DEPTH).
- NOP_INST, 32'h00000013, instruction presented to decode when empty (ADDI x0,x0,0).

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- IF_VALID  input  1  fetch presents a valid word this cycle.
- IF_INST  input  32  fetched instruction.
- IF_PC  input  32  PC of IF_INST.
- IF_READY  output  1  buffer accepts a word this cycle.
- ID_STALL  input  1  decode/hazard unit holds the current head.
- FLUSH  input  1  taken branch/jump resolved downstream; discard all buffered words.
- ID_VALID  output  1  head entry is a real instruction.
- ID_INST  output  32  head instruction, or NOP_INST when ID_VALID=0.
- ID_PC  output  32  head PC, or 32'h0 when ID_VALID=0.
- ID_PC_PLUS4  output  32  ID_PC+4 when valid, else 32'h0.
- COUNT  output  PTR_W+1  occupancy, for debug/perf counters.

Behaviour:
- Reset, asynchronous and active-high: wr_ptr=0, rd_ptr=0, count=0. Outputs are then ID_VALID=0, ID_INST=NOP_INST, ID_PC=0, ID_PC_PLUS4=0, IF_READY=1, COUNT=0. Storage contents are don't-care.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- push = IF_VALID & IF_READY & ~FLUSH.
- pop = ID_VALID & ~ID_STALL & ~FLUSH.
- IF_READY = (count < DEPTH). It is derived from registered count only; there is no combinational path from ID_STALL or FLUSH to IF_READY.
- When the buffer is full, no push occurs in that cycle even if a pop occurs.
- Write on push: mem[wr_ptr] <= {IF_PC, IF_INST}; wr_ptr increments modulo DEPTH and wraps naturally.
- Pop: rd_ptr increments modulo DEPTH.
- count: next = count + push - pop. Simultaneous push and pop leaves count unchanged.
- Output path: ID_* are driven combinationally from mem[rd_ptr] and count (first-word fall-through).
- Latency: a word pushed at edge N appears on ID_* during cycle N+1. Minimum fetch-to-decode latency is 1 cycle.
- ID_VALID = (count != 0).
- ID_PC_PLUS4 uses a 32-bit add with wrap: 32'hFFFFFFFC gives 32'h00000000.
- Empty case: ID_STALL has no effect and no pop occurs. Decode sees NOP_INST, i.e. a bubble.
- FLUSH has priority over everything:
  - At the edge, wr_ptr=rd_ptr=count=0.
  - The word offered on IF_* in the same cycle is dropped, even if IF_READY=1.
  - The next cycle shows ID_VALID=0 and IF_READY=1.
- FLUSH with ID_STALL asserted: the flush still clears the buffer.
- ID_STALL held for many cycles: the head and all ID_* outputs stay stable, bit for bit. The buffer fills to DEPTH, then IF_READY=0.
- Fetch-side handshake: IF_INST/IF_PC are sampled only when push is true. Fetch must hold the word while IF_VALID=1 and IF_READY=0.

Decomposition:
- Shared include/constants file (pipeline_defs): NOP_INST encoding, XLEN=32, and the default fetch buffer depth.
- These constants are reused by the hazard unit and the ID/EX register for bubble insertion.
- One natural sub-module: sync_fifo_fwft, a generic storage array with pointers and count, parameterised on width (64) and depth.
- The top level adds the NOP substitution, the PC+4 adder and the flush priority logic.

Test Plan:
1. Reset with RESET pulsed asynchronously between clock edges -> ID_VALID=0, ID_INST=32'h00000013, IF_READY=1, COUNT=0, all without a clock edge.
2. Streaming: push PC 0x0/0x4/0x8 (INST 0x00500093, 0x00A00113, 0x002081B3) with ID_STALL=0 -> each word appears one cycle after its push; COUNT stays at 1; ID_PC_PLUS4 equals PC+4.
3. Stall fill: ID_STALL=1 with 3 pushes offered -> 2 accepted; IF_READY=0 with COUNT=2; ID_INST holds 0x00500093. Release the stall -> drains in order 0x0, 0x4, then the third word is accepted.
4. Full with simultaneous push and pop: COUNT=2, ID_STALL=0, IF_VALID=1 -> IF_READY=0 and no push; COUNT becomes 1 and the third word is accepted the next cycle.
5. Flush: with COUNT=2, assert FLUSH together with IF_VALID=1 at PC 0x40 -> next cycle COUNT=0, ID_VALID=0, ID_INST=NOP; the 0x40 word is dropped. A later push at PC 0x80 appears as the next head.
6. Wrap-around: push and pop 10 words, PC 0xFFFFFFF0 upward -> pointers wrap correctly; PC 0xFFFFFFFC gives ID_PC_PLUS4=0x00000000; the output order is preserved.
